// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU-side memory bus responder.
// Target bit order is common to selects, tgt_req and tgt_ready.
package mem_bus_pkg;

    localparam int NUM_TARGETS = 4;

    localparam int TGT_BRAM   = 0;
    localparam int TGT_SRAM   = 1;
    localparam int TGT_FLASH  = 2;
    localparam int TGT_PERIPH = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_e;

    function automatic logic is_onehot(input logic [NUM_TARGETS-1:0] v);
        return $countones(v) == 1;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Wait-cycle counter for the ACCESS state; expired flags the last
// permitted cycle so the counter itself never wraps.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == LAST);

endmodule

// File: rtl/mem_bus_responder.sv
// Completion side of the CPU bus: forwards one-hot target requests,
// waits for ready or timeout, and returns a single-cycle completion.
module mem_bus_responder #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic                  bram_select,
    input  logic                  sram_select,
    input  logic                  flash_select,
    input  logic                  peripheral_select,
    input  logic                  decode_error,
    output logic [3:0]            tgt_req,
    output logic                  tgt_we,
    input  logic [3:0]            tgt_ready,
    input  logic [DATA_WIDTH-1:0] bram_rdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    input  logic [DATA_WIDTH-1:0] flash_rdata,
    input  logic [DATA_WIDTH-1:0] periph_rdata,
    output logic                  cpu_ready,
    output logic                  cpu_error,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  busy
);

    import mem_bus_pkg::*;

    state_e                   r_state;
    logic [NUM_TARGETS-1:0]   r_sel;
    logic                     r_we;
    logic                     r_err;
    logic [DATA_WIDTH-1:0]    r_rdata;

    logic [NUM_TARGETS-1:0]   w_sel;
    logic [NUM_TARGETS-1:0]   w_hit;
    logic [DATA_WIDTH-1:0]    w_rdata;
    logic                     w_expired;
    logic                     w_access;
    logic                     w_respond;

    assign w_sel = {peripheral_select, flash_select, sram_select, bram_select};
    // Ready from a target we did not select is masked off here.
    assign w_hit = tgt_ready & r_sel;

    assign w_access  = (r_state == ACCESS);
    assign w_respond = (r_state == RESPOND);

    always_comb begin
        w_rdata = '0;
        if (r_sel[TGT_BRAM]) begin
            w_rdata = bram_rdata;
        end else if (r_sel[TGT_SRAM]) begin
            w_rdata = sram_rdata;
        end else if (r_sel[TGT_FLASH]) begin
            w_rdata = flash_rdata;
        end else if (r_sel[TGT_PERIPH]) begin
            w_rdata = periph_rdata;
        end
    end

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (r_state == IDLE),
        .enable (w_access && (w_hit == '0)),
        .expired(w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_req) begin
                        if (decode_error || !is_onehot(w_sel)) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                            r_state <= RESPOND;
                        end else begin
                            r_sel   <= w_sel;
                            r_we    <= cpu_we;
                            r_state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // Ready takes priority over a timeout in the same cycle.
                    if (w_hit != '0) begin
                        r_rdata <= r_we ? '0 : w_rdata;
                        r_err   <= 1'b0;
                        r_state <= RESPOND;
                    end else if (w_expired) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= RESPOND;
                    end
                end
                RESPOND: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tgt_req   = w_access ? r_sel : '0;
    assign tgt_we    = r_we;
    assign cpu_ready = w_respond;
    assign cpu_error = w_respond & r_err;
    assign cpu_rdata = w_respond ? r_rdata : '0;
    assign busy      = w_access | w_respond;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: zero-wait, wait states,
// decode errors, timeout, reset abort, stray ready, back-to-back.
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic        bram_select;
    logic        sram_select;
    logic        flash_select;
    logic        peripheral_select;
    logic        decode_error;
    logic [3:0]  tgt_req;
    logic        tgt_we;
    logic [3:0]  tgt_ready;
    logic [31:0] bram_rdata;
    logic [31:0] sram_rdata;
    logic [31:0] flash_rdata;
    logic [31:0] periph_rdata;
    logic        cpu_ready;
    logic        cpu_error;
    logic [31:0] cpu_rdata;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_bus_responder #(
        .TIMEOUT_CYCLES(16),
        .DATA_WIDTH    (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cpu_req          (cpu_req),
        .cpu_we           (cpu_we),
        .bram_select      (bram_select),
        .sram_select      (sram_select),
        .flash_select     (flash_select),
        .peripheral_select(peripheral_select),
        .decode_error     (decode_error),
        .tgt_req          (tgt_req),
        .tgt_we           (tgt_we),
        .tgt_ready        (tgt_ready),
        .bram_rdata       (bram_rdata),
        .sram_rdata       (sram_rdata),
        .flash_rdata      (flash_rdata),
        .periph_rdata     (periph_rdata),
        .cpu_ready        (cpu_ready),
        .cpu_error        (cpu_error),
        .cpu_rdata        (cpu_rdata),
        .busy             (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr_sel();
        bram_select       = 1'b0;
        sram_select       = 1'b0;
        flash_select      = 1'b0;
        peripheral_select = 1'b0;
        decode_error      = 1'b0;
    endtask

    task automatic chk_resp(input string tag, input logic err,
                            input logic [31:0] data);
        chk({tag, "_ready"}, {31'd0, cpu_ready}, 32'd1);
        chk({tag, "_error"}, {31'd0, cpu_error}, {31'd0, err});
        chk({tag, "_rdata"}, cpu_rdata, data);
        chk({tag, "_treq"}, {28'd0, tgt_req}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        clr_sel();
        tgt_ready = 4'b0000;
        bram_rdata = 32'h0;
        sram_rdata = 32'h0;
        flash_rdata = 32'h0;
        periph_rdata = 32'h0;
        step();
        step();

        chk("rst_treq", {28'd0, tgt_req}, 32'd0);
        chk("rst_twe", {31'd0, tgt_we}, 32'd0);
        chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_error", {31'd0, cpu_error}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        step();

        // BRAM zero-wait read
        bram_select = 1'b1;
        tgt_ready = 4'b0001;
        bram_rdata = 32'hDEADBEEF;
        cpu_req = 1'b1;
        step();
        cpu_req = 1'b0;
        chk("bram_treq", {28'd0, tgt_req}, 32'h1);
        chk("bram_busy", {31'd0, busy}, 32'd1);
        chk("bram_noready", {31'd0, cpu_ready}, 32'd0);
        step();
        chk_resp("bram", 1'b0, 32'hDEADBEEF);
        step();
        chk("bram_done", {31'd0, cpu_ready}, 32'd0);
        chk("bram_idle_rdata", cpu_rdata, 32'd0);
        chk("bram_idle_busy", {31'd0, busy}, 32'd0);
        tgt_ready = 4'b0000;
        clr_sel();

        // Flash read, ready in the 5th ACCESS cycle
        flash_select = 1'b1;
        flash_rdata = 32'h12345678;
        cpu_req = 1'b1;
        step();
        cpu_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("flash_treq%0d", i), {28'd0, tgt_req}, 32'h4);
            chk($sformatf("flash_wait%0d", i), {31'd0, cpu_ready}, 32'd0);
            step();
        end
        chk("flash_treq5", {28'd0, tgt_req}, 32'h4);
        tgt_ready = 4'b0100;
        step();
        chk_resp("flash", 1'b0, 32'h12345678);
        tgt_ready = 4'b0000;
        step();
        clr_sel();

        // Decode error flag
        bram_select = 1'b1;
        decode_error = 1'b1;
        cpu_req = 1'b1;
        step();
        cpu_req = 1'b0;
        chk_resp("decerr", 1'b1, 32'd0);
        step();
        clr_sel();

        // Two selects high
        bram_select = 1'b1;
        sram_select = 1'b1;
        cpu_req = 1'b1;
        step();
        cpu_req = 1'b0;
        chk_resp("multisel", 1'b1, 32'd0);
        step();
        clr_sel();

        // Peripheral timeout
        peripheral_select = 1'b1;
        periph_rdata = 32'hAAAA5555;
        cpu_req = 1'b1;
        step();
        cpu_req = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("to_treq%0d", i), {28'd0, tgt_req}, 32'h8);
            chk($sformatf("to_wait%0d", i), {31'd0, cpu_ready}, 32'd0);
            step();
        end
        chk_resp("timeout", 1'b1, 32'd0);
        step();

        // Ready in the last allowed cycle beats the timeout
        periph_rdata = 32'hCAFEF00D;
        cpu_req = 1'b1;
        step();
        cpu_req = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("lr_treq%0d", i), {28'd0, tgt_req}, 32'h8);
            if (i == 16) tgt_ready = 4'b1000;
            step();
        end
        chk_resp("lastready", 1'b0, 32'hCAFEF00D);
        tgt_ready = 4'b0000;
        step();
        clr_sel();

        // Reset during the 2nd ACCESS cycle
        bram_select = 1'b1;
        cpu_req = 1'b1;
        step();
        cpu_req = 1'b0;
        step();
        chk("rsta_treq", {28'd0, tgt_req}, 32'h1);
        rst = 1'b1;
        tgt_ready = 4'b0001;
        step();
        chk("rsta_treq0", {28'd0, tgt_req}, 32'd0);
        chk("rsta_busy", {31'd0, busy}, 32'd0);
        chk("rsta_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rsta_twe", {31'd0, tgt_we}, 32'd0);
        rst = 1'b0;
        step();
        chk("rsta_nopulse", {31'd0, cpu_ready}, 32'd0);
        tgt_ready = 4'b0000;

        // Stray SRAM ready during a BRAM access
        sram_rdata = 32'h0BAD0BAD;
        bram_rdata = 32'h0000600D;
        cpu_req = 1'b1;
        step();
        cpu_req = 1'b0;
        tgt_ready = 4'b0010;
        step();
        chk("stray_treq", {28'd0, tgt_req}, 32'h1);
        chk("stray_ready", {31'd0, cpu_ready}, 32'd0);
        tgt_ready = 4'b0011;
        step();
        chk_resp("stray", 1'b0, 32'h0000600D);
        tgt_ready = 4'b0000;
        step();
        clr_sel();

        // Back-to-back: SRAM write, BRAM read, cpu_req held high
        tgt_ready = 4'b0011;
        bram_rdata = 32'h11112222;
        sram_rdata = 32'h99999999;
        sram_select = 1'b1;
        cpu_we = 1'b1;
        cpu_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic wr;
            wr = (k % 2) == 0;
            step();
            chk($sformatf("b2b%0d_treq", k), {28'd0, tgt_req},
                wr ? 32'h2 : 32'h1);
            chk($sformatf("b2b%0d_twe", k), {31'd0, tgt_we}, {31'd0, wr});
            bram_select = wr;
            sram_select = !wr;
            cpu_we = !wr;
            step();
            chk_resp($sformatf("b2b%0d", k), 1'b0,
                     wr ? 32'd0 : 32'h11112222);
            step();
            chk($sformatf("b2b%0d_gap", k), {31'd0, cpu_ready}, 32'd0);
        end
        cpu_req = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
